bram_port_b_arbiter: RTL and testbench

//  Shares port B of the MicroBlaze local-memory BRAM block between two fabric requesters:
//  M0 = BPM capture writer, M1 = readout/DMA reader.

---
 rtl/bram_port_b_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_bram_port_b_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_b_arbiter.sv
// ============================================================================
// Module      : bram_port_b_arbiter
// Description : Round-robin, burst-bounded sharing of BRAM port B between a
//               capture writer (M0) and a readout reader (M1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_b_arbiter #(
    parameter int C_MEMSIZE     = 'h4000,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_NUM_WE      = 4,
    parameter int C_MAX_BURST   = 4
) (
    input  logic                       BRAM_Clk,
    input  logic                       BRAM_Rst_N,
    input  logic                       M0_Req,
    input  logic [0:C_NUM_WE-1]        M0_WEN,
    input  logic [0:C_PORT_AWIDTH-1]   M0_Addr,
    input  logic [0:C_PORT_DWIDTH-1]   M0_WrData,
    output logic                       M0_Ack,
    output logic [0:C_PORT_DWIDTH-1]   M0_RdData,
    output logic                       M0_RdValid,
    output logic                       M0_AddrErr,
    input  logic                       M1_Req,
    input  logic [0:C_NUM_WE-1]        M1_WEN,
    input  logic [0:C_PORT_AWIDTH-1]   M1_Addr,
    input  logic [0:C_PORT_DWIDTH-1]   M1_WrData,
    output logic                       M1_Ack,
    output logic [0:C_PORT_DWIDTH-1]   M1_RdData,
    output logic                       M1_RdValid,
    output logic                       M1_AddrErr,
    output logic                       BRAM_Clk_B,
    output logic                       BRAM_Rst_B,
    output logic                       BRAM_EN_B,
    output logic [0:C_NUM_WE-1]        BRAM_WEN_B,
    output logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_B,
    output logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_B,
    input  logic [0:C_PORT_DWIDTH-1]   BRAM_Din_B
);

    localparam int CW = $clog2(C_MAX_BURST + 1);
    localparam logic [CW-1:0]              MAX_CNT   = CW'(C_MAX_BURST);
    localparam logic [0:C_PORT_AWIDTH-1]   MEM_LIMIT = C_PORT_AWIDTH'(C_MEMSIZE);

    logic                     owner_q, owner_d;
    logic [CW-1:0]            burst_cnt_q, burst_cnt_d;
    logic                     en_q, en_d;
    logic [0:C_NUM_WE-1]      wen_q, wen_d;
    logic [0:C_PORT_AWIDTH-1] addr_q, addr_d;
    logic [0:C_PORT_DWIDTH-1] dout_q, dout_d;
    logic                     err0_q, err0_d, err1_q, err1_d;
    logic                     t1_valid_q, t1_valid_d, t1_id_q, t1_id_d, t1_oor_q, t1_oor_d;
    logic                     t2_valid_q, t2_valid_d, t2_id_q, t2_id_d, t2_oor_q, t2_oor_d;
    logic                     rdv0_q, rdv0_d, rdv1_q, rdv1_d;
    logic [0:C_PORT_DWIDTH-1] rd0_q, rd0_d, rd1_q, rd1_d;

    logic                     win;
    logic                     req_any;
    logic [0:C_NUM_WE-1]      sel_wen;
    logic [0:C_PORT_AWIDTH-1] sel_addr;
    logic [0:C_PORT_DWIDTH-1] sel_data;
    logic                     sel_oor;

    assign req_any = M0_Req | M1_Req;

    // burst_cnt_q == 0 only after reset: no current owner, so a tie goes to the
    // requester opposite the reset owner (M0).
    always_comb begin
        win = owner_q;
        if (M0_Req && !M1_Req) begin
            win = 1'b0;
        end else if (M1_Req && !M0_Req) begin
            win = 1'b1;
        end else if (M0_Req && M1_Req) begin
            win = (burst_cnt_q != '0 && burst_cnt_q < MAX_CNT) ? owner_q : ~owner_q;
        end
    end

    assign M0_Ack   = M0_Req & ~win;
    assign M1_Ack   = M1_Req &  win;
    assign sel_wen  = win ? M1_WEN    : M0_WEN;
    assign sel_addr = win ? M1_Addr   : M0_Addr;
    assign sel_data = win ? M1_WrData : M0_WrData;
    assign sel_oor  = (sel_addr >= MEM_LIMIT);

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        en_d        = 1'b0;
        wen_d       = '0;
        addr_d      = addr_q;
        dout_d      = dout_q;
        err0_d      = err0_q;
        err1_d      = err1_q;
        t1_valid_d  = 1'b0;
        t1_id_d     = t1_id_q;
        t1_oor_d    = t1_oor_q;
        t2_valid_d  = t1_valid_q;
        t2_id_d     = t1_id_q;
        t2_oor_d    = t1_oor_q;
        rdv0_d      = t2_valid_q & ~t2_id_q;
        rdv1_d      = t2_valid_q &  t2_id_q;
        rd0_d       = rd0_q;
        rd1_d       = rd1_q;

        if (req_any) begin
            if (win != owner_q) begin
                owner_d     = win;
                burst_cnt_d = CW'(1);
            end else if (burst_cnt_q < MAX_CNT) begin
                burst_cnt_d = burst_cnt_q + CW'(1);
            end
            if (sel_oor) begin
                err0_d = err0_q | ~win;
                err1_d = err1_q |  win;
            end else begin
                en_d   = 1'b1;
                wen_d  = sel_wen;
                addr_d = sel_addr;
                dout_d = sel_data;
            end
            t1_valid_d = ~|sel_wen;
            t1_id_d    = win;
            t1_oor_d   = sel_oor;
        end

        // Read data for a blocked access is forced to zero.
        if (t2_valid_q && !t2_id_q) rd0_d = t2_oor_q ? '0 : BRAM_Din_B;
        if (t2_valid_q &&  t2_id_q) rd1_d = t2_oor_q ? '0 : BRAM_Din_B;
    end

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            owner_q     <= 1'b1;
            burst_cnt_q <= '0;
            en_q        <= 1'b0;
            wen_q       <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            t1_valid_q  <= 1'b0;
            t1_id_q     <= 1'b0;
            t1_oor_q    <= 1'b0;
            t2_valid_q  <= 1'b0;
            t2_id_q     <= 1'b0;
            t2_oor_q    <= 1'b0;
            rdv0_q      <= 1'b0;
            rdv1_q      <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            en_q        <= en_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            t1_valid_q  <= t1_valid_d;
            t1_id_q     <= t1_id_d;
            t1_oor_q    <= t1_oor_d;
            t2_valid_q  <= t2_valid_d;
            t2_id_q     <= t2_id_d;
            t2_oor_q    <= t2_oor_d;
            rdv0_q      <= rdv0_d;
            rdv1_q      <= rdv1_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
        end
    end

    assign BRAM_Clk_B  = BRAM_Clk;
    assign BRAM_Rst_B  = 1'b0;
    assign BRAM_EN_B   = en_q;
    assign BRAM_WEN_B  = wen_q;
    assign BRAM_Addr_B = addr_q;
    assign BRAM_Dout_B = dout_q;
    assign M0_RdData   = rd0_q;
    assign M0_RdValid  = rdv0_q;
    assign M0_AddrErr  = err0_q;
    assign M1_RdData   = rd1_q;
    assign M1_RdValid  = rdv1_q;
    assign M1_AddrErr  = err1_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_b_arbiter.sv
// ============================================================================
// Module      : tb_bram_port_b_arbiter
// Description : Randomised and directed bench for bram_port_b_arbiter with a
//               behavioural BRAM and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_port_b_arbiter;

    localparam int MAX_BURST = 4;
    localparam logic [31:0] MEMSIZE = 32'h4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic [3:0]  wen [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    wire         ack0, ack1, rdv0, rdv1, err0, err1, clkb, rstb, enb;
    wire  [3:0]  wenb;
    wire  [31:0] rd0, rd1, addrb, doutb;
    logic [31:0] din = '0;

    always #5 clk = ~clk;

    bram_port_b_arbiter #(
        .C_MEMSIZE('h4000), .C_PORT_AWIDTH(32), .C_PORT_DWIDTH(32),
        .C_NUM_WE(4), .C_MAX_BURST(MAX_BURST)
    ) dut (
        .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
        .M0_Req(req[0]), .M0_WEN(wen[0]), .M0_Addr(addr[0]), .M0_WrData(wdata[0]),
        .M0_Ack(ack0), .M0_RdData(rd0), .M0_RdValid(rdv0), .M0_AddrErr(err0),
        .M1_Req(req[1]), .M1_WEN(wen[1]), .M1_Addr(addr[1]), .M1_WrData(wdata[1]),
        .M1_Ack(ack1), .M1_RdData(rd1), .M1_RdValid(rdv1), .M1_AddrErr(err1),
        .BRAM_Clk_B(clkb), .BRAM_Rst_B(rstb), .BRAM_EN_B(enb), .BRAM_WEN_B(wenb),
        .BRAM_Addr_B(addrb), .BRAM_Dout_B(doutb), .BRAM_Din_B(din)
    );

    // Behavioural write-first BRAM; byte lane i of the bench vectors is bits [8i+7:8i].
    logic [31:0] bmem [0:4095];
    logic [31:0] bw;
    initial for (int i = 0; i < 4096; i++) bmem[i] = '0;
    always @(posedge clk) begin
        if (enb) begin
            bw = bmem[addrb[13:2]];
            for (int i = 0; i < 4; i++) if (wenb[i]) bw[8*i +: 8] = doutb[8*i +: 8];
            bmem[addrb[13:2]] <= bw;
            din <= bw;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: arbitration history, memory image and expected returns.
    typedef struct { int due; int id; logic [31:0] data; } ret_t;
    ret_t        retq [$];
    int          grant_log [$];
    logic [31:0] ref_mem [int];
    int          m_owner, m_run, cyc, last_win;
    bit          m_err [2];
    logic [31:0] last_rd [2];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
    endfunction

    task automatic step();
        int w;
        bit oor, exp_en;
        bit exp_v [2];
        logic [31:0] exp_d [2];
        logic [31:0] word;
        @(negedge clk);
        w = -1;
        if (req[0] && !req[1])      w = 0;
        else if (req[1] && !req[0]) w = 1;
        else if (req[0] && req[1])  w = (m_run > 0 && m_run < MAX_BURST) ? m_owner : 1 - m_owner;
        check("ack0", ack0, w == 0);
        check("ack1", ack1, w == 1);
        @(posedge clk);
        cyc++;
        exp_en = 0;
        last_win = w;
        if (w >= 0) begin
            grant_log.push_back(w);
            if (w == m_owner) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
            else begin m_owner = w; m_run = 1; end
            oor = addr[w] >= MEMSIZE;
            if (oor) m_err[w] = 1;
            else begin
                exp_en = 1;
                if (wen[w] != 0) begin
                    word = ref_rd(addr[w]);
                    for (int i = 0; i < 4; i++) if (wen[w][i]) word[8*i +: 8] = wdata[w][8*i +: 8];
                    ref_mem[int'(addr[w] >> 2)] = word;
                end
            end
            if (wen[w] == 0) retq.push_back('{due: cyc + 2, id: w, data: oor ? 32'h0 : ref_rd(addr[w])});
        end
        #1;
        check("en_b", enb, exp_en);
        exp_v = '{0, 0};
        exp_d = '{32'h0, 32'h0};
        if (retq.size() > 0 && retq[0].due == cyc) begin
            exp_v[retq[0].id] = 1;
            exp_d[retq[0].id] = retq[0].data;
            void'(retq.pop_front());
        end
        check("rdvalid0", rdv0, exp_v[0]);
        check("rdvalid1", rdv1, exp_v[1]);
        if (exp_v[0]) begin check("rddata0", rd0, exp_d[0]); last_rd[0] = rd0; end
        if (exp_v[1]) begin check("rddata1", rd1, exp_d[1]); last_rd[1] = rd1; end
        check("addrerr0", err0, m_err[0]);
        check("addrerr1", err1, m_err[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '{1'b0, 1'b0};
        #1;
        check("rst_rdv0", rdv0, 0);   check("rst_rdv1", rdv1, 0);
        check("rst_rd0", rd0, 0);     check("rst_rd1", rd1, 0);
        check("rst_en", enb, 0);      check("rst_wen", wenb, 0);
        check("rst_addr", addrb, 0);  check("rst_dout", doutb, 0);
        check("rst_err0", err0, 0);   check("rst_err1", err1, 0);
        check("rst_rstb", rstb, 0);
        m_owner = 1; m_run = 0; m_err = '{0, 0};
        retq.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_rdv1", rdv1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int i, input logic r, input logic [3:0] we,
                           input logic [31:0] a, input logic [31:0] d);
        req[i] = r; wen[i] = we; addr[i] = a; wdata[i] = d;
    endtask

    task automatic drain(input int n);
        req = '{1'b0, 1'b0};
        repeat (n) step();
    endtask

    initial begin
        cyc = 0;
        set_txn(0, 0, 4'h0, 0, 0);
        set_txn(1, 0, 4'h0, 0, 0);
        do_reset();

        // Write then read-back through the other requester.
        set_txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF); step();
        set_txn(0, 0, 4'h0, 0, 0);
        set_txn(1, 1, 4'h0, 32'h10, 0); step();
        drain(3);
        check("t1_readback", last_rd[1], 32'hDEADBEEF);

        // Contention with bounded bursts from a fresh reset.
        do_reset();
        grant_log.delete();
        set_txn(0, 1, 4'h0, 32'h20, 0);
        set_txn(1, 1, 4'h0, 32'h24, 0);
        repeat (12) step();
        check("t2_grants", grant_log.size(), 12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++)
            check($sformatf("t2_grant%0d", i), grant_log[i], (i / 4) % 2);
        drain(3);

        // Lone reader, back-to-back.
        grant_log.delete();
        for (int i = 0; i < 10; i++) begin set_txn(1, 1, 4'h0, 32'(4 * i), 0); step(); end
        drain(3);
        check("t3_accepts", grant_log.size(), 10);

        // Out-of-range read.
        set_txn(0, 1, 4'h0, 32'h4000, 0); step();
        drain(3);
        check("t4_rd0_zero", last_rd[0], 32'h0);
        check("t4_err0", err0, 1);

        // Byte-lane write merge.
        set_txn(0, 1, 4'hF, 32'h8, 32'h11111111); step();
        set_txn(0, 1, 4'b0100, 32'h8, 32'h00AB0000); step();
        set_txn(0, 1, 4'h0, 32'h8, 0); step();
        drain(3);
        check("t5_merge", last_rd[0], 32'h11AB1111);

        // Reset with a read in flight, then first tie goes to M0.
        set_txn(1, 1, 4'h0, 32'h8, 0); step();
        req = '{1'b0, 1'b0}; step();
        do_reset();
        set_txn(0, 1, 4'h0, 32'h0, 0);
        set_txn(1, 1, 4'h0, 32'h4, 0);
        step();
        check("t6_first_tie", last_win, 0);
        drain(3);

        // Randomised traffic; requests stay stable until acknowledged.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || last_win == i) begin
                    logic [3:0]  we;
                    logic [31:0] a;
                    case ($urandom_range(0, 3))
                        0, 1:    we = 4'h0;
                        2:       we = 4'hF;
                        default: we = 4'($urandom);
                    endcase
                    a = ($urandom_range(0, 19) == 0) ? 32'h4000 + 32'($urandom_range(0, 15) * 4)
                                                     : 32'($urandom_range(0, 15) * 4);
                    set_txn(i, ($urandom_range(0, 3) != 0), we, a, $urandom);
                end
            end
            step();
        end
        drain(4);
        check("rand_queue_empty", retq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
